if_id_buffer: RTL and testbench

- Fetch-to-decode pipeline buffer between the instruction fetch stage and the decode stage.
- Captures each valid (PC+2, instruction) pair produced by fetch into a small FIFO and presents the oldest entry to decode.
- Absorbs decode stalls without dropping instructions that are already fetched. Returns backpressure to fetch.
- Squashes all contents on a taken branch. Emits the NOP encoding whenever it has nothing valid to present.

---
 rtl/if_id_buffer_if.sv | 38 +++
 rtl/if_id_buffer.sv | 122 ++++++++++++
 tb/tb_if_id_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_buffer_if.sv
// ----------------------------------------------------------------------------
// if_id_buffer_if
// Bundles the fetch-side and decode-side signals of the IF/ID pipeline buffer.
//   master : driven by the fetch/decode environment (instruction in, stall, flush)
//   slave  : the buffer itself (head entry out, full, occupancy count)
// Signals:
//   PCAdd2_in, Inst_in, valid_in : fetched (PC+2, instruction) pair and its valid
//   stall_ID                     : decode cannot consume this cycle
//   flush                        : taken branch/jump, discard buffered entries
//   PCAdd2_out, Inst_out         : head entry (0 / NOP when not valid)
//   valid_out                    : head entry is a real instruction
//   full                         : buffer holds DEPTH entries, fetch must hold PC
//   count                        : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
interface if_id_buffer_if #(
  parameter int PTR_W = 1
);
  logic [15:0]    PCAdd2_in;
  logic [15:0]    Inst_in;
  logic           valid_in;
  logic           stall_ID;
  logic           flush;
  logic [15:0]    PCAdd2_out;
  logic [15:0]    Inst_out;
  logic           valid_out;
  logic           full;
  logic [PTR_W:0] count;

  modport master (
    output PCAdd2_in, Inst_in, valid_in, stall_ID, flush,
    input  PCAdd2_out, Inst_out, valid_out, full, count
  );

  modport slave (
    input  PCAdd2_in, Inst_in, valid_in, stall_ID, flush,
    output PCAdd2_out, Inst_out, valid_out, full, count
  );
endinterface

// File: rtl/if_id_buffer.sv
// ----------------------------------------------------------------------------
// if_id_buffer
// Fetch-to-decode pipeline buffer: a DEPTH-entry FIFO of (PC+2, instruction)
// pairs. Absorbs decode stalls, returns backpressure to fetch through full,
// squashes everything on flush and presents NOP_INST when empty.
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, overrides push/pop/flush
//   bus  : if_id_buffer_if.slave (fetch inputs, stall/flush, head outputs)
// Optional build macro:
//   IF_ID_BYPASS_EN : when defined, an idle buffer passes a fetched pair
//                     straight to the outputs in the same cycle (decode not
//                     stalled, no flush) without storing it. When undefined
//                     there is no combinational path from inputs to outputs.
// ----------------------------------------------------------------------------
module if_id_buffer #(
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = 1,
  parameter logic [15:0] NOP_INST = 16'b0000100000000000
) (
  input  logic          clk,
  input  logic          rst,
  if_id_buffer_if.slave bus
);

  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [31:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   cnt_r;

  logic             empty_s;
  logic             full_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      head_s;

  assign empty_s = (cnt_r == CNT_ZERO);
  // full depends only on state, so it carries no path from stall_ID
  assign full_s  = (cnt_r == CNT_FULL);

`ifdef IF_ID_BYPASS_EN
  // Idle buffer and a consuming decode: hand the pair straight through
  assign bypass_s = empty_s & bus.valid_in & ~bus.stall_ID & ~bus.flush;
`else
  assign bypass_s = 1'b0;
`endif

  // A full buffer refuses a push even when a pop happens the same cycle
  assign push_s = bus.valid_in & ~full_s & ~bus.flush & ~bypass_s;
  assign pop_s  = ~empty_s & ~bus.stall_ID & ~bus.flush;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else if (bus.flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      cnt_r    <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_r[wr_ptr_r] <= {bus.PCAdd2_in, bus.Inst_in};
    end
  end

  // Head presentation: NOP and zero PC whenever nothing valid is held
  always_comb begin
    head_s         = mem_r[rd_ptr_r];
    bus.PCAdd2_out = 16'h0000;
    bus.Inst_out   = NOP_INST;
    bus.valid_out  = 1'b0;
`ifdef IF_ID_BYPASS_EN
    if (bypass_s) begin
      bus.PCAdd2_out = bus.PCAdd2_in;
      bus.Inst_out   = bus.Inst_in;
      bus.valid_out  = 1'b1;
    end else
`endif
    if (empty_s) begin
      bus.PCAdd2_out = 16'h0000;
      bus.Inst_out   = NOP_INST;
      bus.valid_out  = 1'b0;
    end else begin
      bus.PCAdd2_out = head_s[31:16];
      bus.Inst_out   = head_s[15:0];
      bus.valid_out  = 1'b1;
    end
  end

  assign bus.full  = full_s;
  assign bus.count = cnt_r;

endmodule

// File: tb/tb_if_id_buffer.sv
// ----------------------------------------------------------------------------
// tb_if_id_buffer
// Directed bench for if_id_buffer (DEPTH=2): reset/idle, streaming, stall fill
// with fetch hold, flush squash, mid-stream reset, pointer wrap with random
// stalls against an in-order expectation, and the idle pass-through case.
// ----------------------------------------------------------------------------
module tb_if_id_buffer;

  localparam int          DEPTH = 2;
  localparam int          PTR_W = 1;
  localparam logic [15:0] NOP   = 16'h0800;
  localparam int          N_WRAP = 24;

  logic clk = 1'b0;
  logic rst;
  int   check_cnt = 0;
  int   err_cnt   = 0;
  logic beef_seen = 1'b0;

  if_id_buffer_if #(.PTR_W(PTR_W)) bus_if ();

  if_id_buffer #(
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .NOP_INST (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Watch for the squashed instruction ever reaching decode
  always @(negedge clk) begin
    if (bus_if.valid_out && bus_if.Inst_out == 16'hBEEF) begin
      beef_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc);
    bus_if.valid_in  = v;
    bus_if.Inst_in   = inst;
    bus_if.PCAdd2_in = pc;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [15:0] inst,
                            input logic [15:0] pc, input int cnt);
    check({tag, "_valid"}, 32'(bus_if.valid_out), 32'(v));
    check({tag, "_inst"},  32'(bus_if.Inst_out),  32'(inst));
    check({tag, "_pc"},    32'(bus_if.PCAdd2_out), 32'(pc));
    check({tag, "_count"}, 32'(bus_if.count),     32'(cnt));
    check({tag, "_full"},  32'(bus_if.full),      32'(cnt == DEPTH));
  endtask

  logic [15:0] s_inst [3] = '{16'h1111, 16'h2222, 16'h3333};
  logic [15:0] s_pc   [3] = '{16'h0002, 16'h0004, 16'h0006};

  initial begin
    int  fi;
    int  ci;
    int  cyc;
    logic push_ok;

    rst = 1'b1;
    bus_if.stall_ID = 1'b0;
    bus_if.flush    = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);

    // Reset held two cycles, then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_head("reset_idle", 1'b0, NOP, 16'h0000, 0);

    // Streaming with decode consuming every cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_inst[i], s_pc[i]);
`ifdef IF_ID_BYPASS_EN
      #1;
      check_head("stream_bypass", 1'b1, s_inst[i], s_pc[i], 0);
      tick();
`else
      tick();
      check_head("stream", 1'b1, s_inst[i], s_pc[i], 1);
`endif
    end
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check_head("stream_drain", 1'b0, NOP, 16'h0000, 0);

    // Stall fill: two entries fill the buffer, third is held by fetch
    bus_if.stall_ID = 1'b1;
    drive(1'b1, 16'hA001, 16'h0100);
    tick();
    check_head("fill1", 1'b1, 16'hA001, 16'h0100, 1);
    drive(1'b1, 16'hA002, 16'h0102);
    tick();
    check_head("fill2", 1'b1, 16'hA001, 16'h0100, 2);
    drive(1'b1, 16'hA003, 16'h0104);
    tick();
    check_head("fill_hold", 1'b1, 16'hA001, 16'h0100, 2);
    bus_if.stall_ID = 1'b0;
    tick();
    check_head("release1", 1'b1, 16'hA002, 16'h0102, 1);
    tick();
    check_head("release2", 1'b1, 16'hA003, 16'h0104, 1);
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check_head("release_empty", 1'b0, NOP, 16'h0000, 0);

    // Flush with a same-cycle fetch and a stalled decode
    bus_if.stall_ID = 1'b1;
    drive(1'b1, 16'hC001, 16'h0200);
    tick();
    drive(1'b1, 16'hC002, 16'h0202);
    tick();
    check_head("pre_flush", 1'b1, 16'hC001, 16'h0200, 2);
    bus_if.flush = 1'b1;
    drive(1'b1, 16'hBEEF, 16'h0300);
    tick();
    check_head("flush", 1'b0, NOP, 16'h0000, 0);
    bus_if.flush    = 1'b0;
    bus_if.stall_ID = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check_head("post_flush", 1'b0, NOP, 16'h0000, 0);

    // Reset asserted mid-stream discards held entries
    bus_if.stall_ID = 1'b1;
    drive(1'b1, 16'hE001, 16'h0500);
    tick();
    check_head("pre_rst", 1'b1, 16'hE001, 16'h0500, 1);
    rst = 1'b1;
    drive(1'b1, 16'hE002, 16'h0502);
    tick();
    rst = 1'b0;
    bus_if.stall_ID = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    check_head("mid_rst", 1'b0, NOP, 16'h0000, 0);

    // Pointer wrap with random stalls and fetch bubbles
    fi  = 0;
    ci  = 0;
    cyc = 0;
    while (ci < N_WRAP && cyc < 400) begin
      bus_if.stall_ID = ($urandom_range(0, 2) == 0);
      drive((fi < N_WRAP) && ($urandom_range(0, 4) != 0),
            16'hD000 + 16'(fi), 16'h1000 + 16'(2 * fi));
      #1;
      push_ok = bus_if.valid_in && !bus_if.full;
      if (bus_if.valid_out && !bus_if.stall_ID) begin
        check("wrap_inst", 32'(bus_if.Inst_out),   32'(16'hD000 + 16'(ci)));
        check("wrap_pc",   32'(bus_if.PCAdd2_out), 32'(16'h1000 + 16'(2 * ci)));
        ci++;
      end
      if (push_ok) begin
        fi++;
      end
      tick();
      cyc++;
    end
    check("wrap_delivered", 32'(ci), 32'(N_WRAP));
    bus_if.stall_ID = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    #1;
    check_head("wrap_empty", 1'b0, NOP, 16'h0000, 0);

    // Idle buffer receiving one instruction with decode free
    drive(1'b1, 16'h4C2D, 16'h0400);
    #1;
`ifdef IF_ID_BYPASS_EN
    check_head("bypass_same", 1'b1, 16'h4C2D, 16'h0400, 0);
    tick();
`else
    check_head("nobypass_same", 1'b0, NOP, 16'h0000, 0);
    tick();
    check_head("nobypass_next", 1'b1, 16'h4C2D, 16'h0400, 1);
`endif
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    check_head("final_idle", 1'b0, NOP, 16'h0000, 0);

    check("beef_squashed", 32'(beef_seen), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
